// File: rtl/l1dcache_port_arbiter.sv
// Two-client arbiter for the single L1 data-cache port: cpu has priority, and
// aux is bounded by a starvation counter. The owner of each request gets the response.
module l1dcache_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned ADDR_W       = 30,
   parameter int unsigned DATA_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req_valid,
   input  logic              cpu_req_we,
   input  logic [ADDR_W-1:0] cpu_req_addr,
   input  logic [DATA_W-1:0] cpu_req_data,
   input  logic [3:0]        cpu_req_mask,
   output logic              cpu_resp_ack,
   output logic [DATA_W-1:0] cpu_resp_data,
   input  logic              aux_req_valid,
   input  logic              aux_req_we,
   input  logic [ADDR_W-1:0] aux_req_addr,
   input  logic [DATA_W-1:0] aux_req_data,
   input  logic [3:0]        aux_req_mask,
   output logic              aux_resp_ack,
   output logic [DATA_W-1:0] aux_resp_data,
   output logic              cache_req_valid,
   output logic              cache_req_we,
   output logic [ADDR_W-1:0] cache_req_addr,
   output logic [DATA_W-1:0] cache_req_data,
   output logic [3:0]        cache_req_mask,
   input  logic              cache_resp_ack,
   input  logic [DATA_W-1:0] cache_resp_data,
   output logic              aux_grant
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic       own_valid_q, own_valid_d;
   logic       own_aux_q, own_aux_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   logic       force_aux;
   logic       aux_gnt;
   logic       cpu_gnt;

   always_comb begin
      force_aux = starve_cnt_q >= LIMIT;
      aux_gnt   = rst_n && aux_req_valid && (!cpu_req_valid || force_aux);
      cpu_gnt   = rst_n && cpu_req_valid && !aux_gnt;
   end

   // Idle cycles still present the cpu fields, with valid low.
   always_comb begin
      aux_grant       = aux_gnt;
      cache_req_valid = cpu_gnt || aux_gnt;
      if (aux_gnt) begin
         cache_req_we   = aux_req_we;
         cache_req_addr = aux_req_addr;
         cache_req_data = aux_req_data;
         cache_req_mask = aux_req_mask;
      end else begin
         cache_req_we   = cpu_req_we;
         cache_req_addr = cpu_req_addr;
         cache_req_data = cpu_req_data;
         cache_req_mask = cpu_req_mask;
      end
   end

   always_comb begin
      cpu_resp_ack  = rst_n && own_valid_q && !own_aux_q && cache_resp_ack;
      aux_resp_ack  = rst_n && own_valid_q && own_aux_q && cache_resp_ack;
      cpu_resp_data = cache_resp_data;
      aux_resp_data = cache_resp_data;
   end

   always_comb begin
      own_valid_d = cache_req_valid;
      own_aux_d   = aux_gnt;
      if (aux_gnt || !aux_req_valid) begin
         starve_cnt_d = 4'd0;
      end else if (starve_cnt_q != 4'hf) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         own_valid_q  <= 1'b0;
         own_aux_q    <= 1'b0;
         starve_cnt_q <= 4'd0;
      end else begin
         own_valid_q  <= own_valid_d;
         own_aux_q    <= own_aux_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: tb/tb_l1dcache_port_arbiter.sv
// Directed bench for l1dcache_port_arbiter: reset, routing, starvation
// pattern, counter clear, miss pass-through and reset mid-flight.
module tb_l1dcache_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req_valid, cpu_req_we;
   logic [29:0] cpu_req_addr;
   logic [31:0] cpu_req_data;
   logic [3:0]  cpu_req_mask;
   logic        cpu_resp_ack;
   logic [31:0] cpu_resp_data;
   logic        aux_req_valid, aux_req_we;
   logic [29:0] aux_req_addr;
   logic [31:0] aux_req_data;
   logic [3:0]  aux_req_mask;
   logic        aux_resp_ack;
   logic [31:0] aux_resp_data;
   logic        cache_req_valid, cache_req_we;
   logic [29:0] cache_req_addr;
   logic [31:0] cache_req_data;
   logic [3:0]  cache_req_mask;
   logic        cache_resp_ack;
   logic [31:0] cache_resp_data;
   logic        aux_grant;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int fail_cnt = 0;

   always #5 clk = ~clk;

   l1dcache_port_arbiter #(
      .STARVE_LIMIT(4), .ADDR_W(30), .DATA_W(32)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
      .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
      .cpu_req_mask(cpu_req_mask),
      .cpu_resp_ack(cpu_resp_ack), .cpu_resp_data(cpu_resp_data),
      .aux_req_valid(aux_req_valid), .aux_req_we(aux_req_we),
      .aux_req_addr(aux_req_addr), .aux_req_data(aux_req_data),
      .aux_req_mask(aux_req_mask),
      .aux_resp_ack(aux_resp_ack), .aux_resp_data(aux_resp_data),
      .cache_req_valid(cache_req_valid), .cache_req_we(cache_req_we),
      .cache_req_addr(cache_req_addr), .cache_req_data(cache_req_data),
      .cache_req_mask(cache_req_mask),
      .cache_resp_ack(cache_resp_ack), .cache_resp_data(cache_resp_data),
      .aux_grant(aux_grant)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [9:0] pat;
   logic [9:0] pat2;

   initial begin
      rst_n           = 1'b0;
      cpu_req_valid   = 1'b1;
      cpu_req_we      = 1'b0;
      cpu_req_addr    = 30'h100;
      cpu_req_data    = 32'h0;
      cpu_req_mask    = 4'hf;
      aux_req_valid   = 1'b1;
      aux_req_we      = 1'b0;
      aux_req_addr    = 30'h200;
      aux_req_data    = 32'h0;
      aux_req_mask    = 4'hf;
      cache_resp_ack  = 1'b1;
      cache_resp_data = 32'h5555_5555;

      tick();
      tick();
      #1;
      chk("rst_req_valid", 64'(cache_req_valid), 64'd0);
      chk("rst_aux_grant", 64'(aux_grant), 64'd0);
      chk("rst_cpu_ack", 64'(cpu_resp_ack), 64'd0);
      chk("rst_aux_ack", 64'(aux_resp_ack), 64'd0);

      // First cycle after release: no owner, so no ack.
      tick();
      rst_n         = 1'b1;
      cpu_req_valid = 1'b0;
      aux_req_valid = 1'b0;
      #1;
      chk("post_rst_cpu_ack", 64'(cpu_resp_ack), 64'd0);
      chk("post_rst_aux_ack", 64'(aux_resp_ack), 64'd0);
      chk("idle_valid", 64'(cache_req_valid), 64'd0);
      chk("idle_addr", 64'(cache_req_addr), 64'h100);

      tick();
      cpu_req_valid = 1'b1;
      cpu_req_addr  = 30'h10;
      cpu_req_mask  = 4'b1111;
      #1;
      chk("ld_valid", 64'(cache_req_valid), 64'd1);
      chk("ld_addr", 64'(cache_req_addr), 64'h10);
      chk("ld_mask", 64'(cache_req_mask), 64'hf);
      chk("ld_aux_grant", 64'(aux_grant), 64'd0);
      tick();
      cpu_req_valid   = 1'b0;
      cache_resp_ack  = 1'b1;
      cache_resp_data = 32'hDEAD_BEEF;
      #1;
      chk("ld_cpu_ack", 64'(cpu_resp_ack), 64'd1);
      chk("ld_cpu_data", 64'(cpu_resp_data), 64'hDEADBEEF);
      chk("ld_aux_ack", 64'(aux_resp_ack), 64'd0);

      // Continuous contention, counter starting from zero.
      pat           = 10'b10_0001_0000;
      cpu_req_addr  = 30'h111;
      aux_req_addr  = 30'h222;
      for (int i = 0; i < 10; i++) begin
         tick();
         cpu_req_valid  = 1'b1;
         aux_req_valid  = 1'b1;
         cache_resp_ack = 1'b1;
         #1;
         chk($sformatf("cont_grant%0d", i), 64'(aux_grant), 64'(pat[i]));
         chk($sformatf("cont_addr%0d", i), 64'(cache_req_addr),
             pat[i] ? 64'h222 : 64'h111);
         if (i > 0) begin
            chk($sformatf("cont_cack%0d", i), 64'(cpu_resp_ack),
                64'(!pat[i-1]));
            chk($sformatf("cont_aack%0d", i), 64'(aux_resp_ack),
                64'(pat[i-1]));
         end
      end
      tick();
      cpu_req_valid = 1'b0;
      aux_req_valid = 1'b0;
      #1;
      chk("cont_last_aack", 64'(aux_resp_ack), 64'd1);
      chk("cont_last_cack", 64'(cpu_resp_ack), 64'd0);

      // Three losses, one idle aux cycle, then four fresh losses.
      pat2 = 10'b1_0000_0000;
      for (int i = 0; i < 9; i++) begin
         tick();
         cpu_req_valid = 1'b1;
         aux_req_valid = (i != 3);
         #1;
         chk($sformatf("clr_grant%0d", i), 64'(aux_grant), 64'(pat2[i]));
         chk($sformatf("clr_valid%0d", i), 64'(cache_req_valid), 64'd1);
      end

      // Aux drops while it would be forced: cpu wins with no gap.
      for (int i = 0; i < 4; i++) begin
         tick();
         cpu_req_valid = 1'b1;
         aux_req_valid = 1'b1;
         #1;
         chk($sformatf("drop_lose%0d", i), 64'(aux_grant), 64'd0);
      end
      tick();
      aux_req_valid = 1'b0;
      #1;
      chk("drop_valid", 64'(cache_req_valid), 64'd1);
      chk("drop_addr", 64'(cache_req_addr), 64'h111);
      chk("drop_grant", 64'(aux_grant), 64'd0);
      tick();
      aux_req_valid = 1'b1;
      #1;
      chk("drop_cleared", 64'(aux_grant), 64'd0);

      // Aux store alone, missed once, then retried and acked.
      tick();
      cpu_req_valid = 1'b0;
      aux_req_valid = 1'b1;
      aux_req_we    = 1'b1;
      aux_req_addr  = 30'h2A;
      aux_req_data  = 32'h1234_5678;
      aux_req_mask  = 4'b0011;
      #1;
      chk("st_grant", 64'(aux_grant), 64'd1);
      chk("st_we", 64'(cache_req_we), 64'd1);
      chk("st_addr", 64'(cache_req_addr), 64'h2A);
      chk("st_data", 64'(cache_req_data), 64'h12345678);
      chk("st_mask", 64'(cache_req_mask), 64'h3);
      tick();
      cache_resp_ack = 1'b0;
      #1;
      chk("miss_aack", 64'(aux_resp_ack), 64'd0);
      chk("miss_cack", 64'(cpu_resp_ack), 64'd0);
      chk("retry_grant", 64'(aux_grant), 64'd1);
      tick();
      aux_req_valid  = 1'b0;
      aux_req_we     = 1'b0;
      cache_resp_ack = 1'b1;
      #1;
      chk("retry_aack", 64'(aux_resp_ack), 64'd1);
      chk("retry_cack", 64'(cpu_resp_ack), 64'd0);

      // Reset lands on the edge after a cpu grant.
      tick();
      cpu_req_valid = 1'b1;
      #1;
      chk("mid_grant", 64'(cache_req_valid), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_gated", 64'(cache_req_valid), 64'd0);
      tick();
      rst_n          = 1'b1;
      cpu_req_valid  = 1'b0;
      cache_resp_ack = 1'b1;
      #1;
      chk("mid_cack", 64'(cpu_resp_ack), 64'd0);
      chk("mid_aack", 64'(aux_resp_ack), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/l1dcache_port_arbiter.md
# l1dcache_port_arbiter

Shares the single L1 data-cache core port between the memory stage (client 0, `cpu`) and an auxiliary requester (client 1, `aux`: debug/DMA/page walker). Fixed priority favours `cpu`, and a starvation counter bounds how long `aux` can wait. The block tracks which client owns the single in-flight request and routes the next-cycle response to it. The losing client sees a nack and retries, which the memory stage already handles as `memNack`.

## Interface
- `STARVE_LIMIT`, 4: consecutive denied `aux` request cycles before `aux` is forced ahead of `cpu`; legal range 1..15.
- `ADDR_W`, 30: word address width.
- `DATA_W`, 32: data width.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; one clock, reset synchronous, active-low.
- `cpu_req_valid`, `cpu_req_we`  in  1 each  memory-stage request and write enable.
- `cpu_req_addr`  in  ADDR_W  word address.
- `cpu_req_data`  in  DATA_W  store data.
- `cpu_req_mask`  in  4  byte mask.
- `cpu_resp_ack`  out  1  request of previous cycle was accepted and completed by cache.
- `cpu_resp_data`  out  DATA_W  load data, valid with `cpu_resp_ack`.
- `aux_req_valid`, `aux_req_we`, `aux_req_addr`, `aux_req_data`, `aux_req_mask`  in  same widths as `cpu_*`  auxiliary request.
- `aux_resp_ack`  out  1  as `cpu_resp_ack`, for `aux`.
- `aux_resp_data`  out  DATA_W  as `cpu_resp_data`, for `aux`.
- `cache_req_valid`, `cache_req_we`, `cache_req_addr`, `cache_req_data`, `cache_req_mask`  out  same widths  to cache.
- `cache_resp_ack`  in  1  cache response, one cycle after the request.
- `cache_resp_data`  in  DATA_W  cache response data.
- `aux_grant`  out  1  debug: `aux` owns the cache request this cycle.

## Operation
- Grant is decided combinationally each cycle; at most one client is forwarded.
  - `force_aux = starve_cnt >= STARVE_LIMIT`.
  - `aux_grant = aux_req_valid && (!cpu_req_valid || force_aux)`.
  - `cpu_grant = cpu_req_valid && !aux_grant`.
- Request mux: `cache_req_*` equal the granted client's fields. `cache_req_valid = cpu_grant || aux_grant`.
  - When neither client is granted, `cache_req_addr/data/mask/we` are driven from `cpu_*` and `cache_req_valid` is 0.
- Owner register, updated every edge:
  - `own_valid <= cache_req_valid`.
  - `own_aux <= aux_grant`.
- Response routing, combinational:
  - `cpu_resp_ack = own_valid && !own_aux && cache_resp_ack`.
  - `aux_resp_ack = own_valid && own_aux && cache_resp_ack`.
  - Both `*_resp_data` carry `cache_resp_data` unconditionally; consumers qualify with ack.
- A client that requested and was not granted sees `resp_ack=0` next cycle, which is a nack. A cache miss (`cache_resp_ack=0` while owner) is also a nack. The arbiter never buffers or replays; clients re-present the request.
- Starvation counter `starve_cnt` is 4 bits and saturates at 15.
  - Increment when `aux_req_valid && !aux_grant`.
  - Clear when `aux_grant`, or when `!aux_req_valid`.
  - Otherwise hold.
- `aux` winning while `cpu_req_valid` is high is a loss for `cpu`: `cpu` gets a nack and the memory stage replays.

## Timing
- Request path is zero-latency combinational, inputs to `cache_req_*`.
- Response latency is 1 cycle: the response of the cycle-N request appears in cycle N+1 on the owner's port only.
- Reset (`rst_n=0` sampled at an edge) sets:
  - `own_valid=0`, `own_aux=0`, `starve_cnt=0`.
- While `rst_n=0`, outputs are combinationally gated:
  - `cache_req_valid=0`, `aux_grant=0`, `cpu_resp_ack=0`, `aux_resp_ack=0`.
- Reset mid-operation: the in-flight response in the cycle after reset is dropped, since `own_valid` is cleared. The cache may still complete a store issued before reset; this is acceptable.
- Back-to-back requests from both clients:
  - `cpu` wins `STARVE_LIMIT` cycles in a row.
  - In cycle `STARVE_LIMIT`+1, `aux` wins and the counter clears.
  - The pattern then repeats.
- Simultaneous `aux` grant and `cache_resp_ack` for a previous `cpu` request: the response goes to `cpu` and the new ownership goes to `aux`; there is no interference.
- `aux` dropping its request while being forced: the counter clears, `cpu` wins immediately, and no idle cycle is inserted.

## Test plan
- Reset: hold `rst_n=0` with both requests high and `cache_resp_ack=1` -> all req/ack outputs 0. After release, the first-cycle `cache_resp_ack=1` yields no client ack.
- Single client: `cpu` load at addr 0x10 with mask 4'b1111; the cache acks next cycle with data 0xDEADBEEF -> `cpu_resp_ack=1`, `cpu_resp_data=0xDEADBEEF`, `aux_resp_ack=0`.
- Contention with `STARVE_LIMIT=4`: both request continuously for 10 cycles -> grants are cpu,cpu,cpu,cpu,aux,cpu,cpu,cpu,cpu,aux, and each loser sees `resp_ack=0` one cycle later.
- Counter clear: `aux` requests for 3 losing cycles, drops for 1 cycle, then requests again alongside `cpu` -> `aux` needs 4 more losses before a grant.
- Cache miss pass-through: `aux` granted alone as a store with mask 4'b0011; the cache returns `cache_resp_ack=0` -> `aux_resp_ack=0` and `cpu_resp_ack=0`. The retried `aux` request is acked next time.
- Reset mid-flight: `cpu` granted in cycle N and `rst_n=0` at edge N+1 -> `cpu_resp_ack=0` in cycle N+1 despite `cache_resp_ack=1`.
